// File: rtl/binary_clock_top.sv
// Binary clock: divides the board clock to a 1 Hz tick, keeps 24-hour BCD time
// and shows one selected BCD digit on four LEDs.
module binary_clock_top #(
    parameter int unsigned CLK_DIV     = 12000000,
    parameter int unsigned DISPLAY_SEL = 0
) (
    input  logic clk,
    input  logic rst_n,
    output logic led1,
    output logic led2,
    output logic led3,
    output logic led4
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;

    logic [3:0] sec_u_q, sec_u_d;
    logic [2:0] sec_t_q, sec_t_d;
    logic [3:0] min_u_q, min_u_d;
    logic [2:0] min_t_q, min_t_d;
    logic [3:0] hr_u_q, hr_u_d;
    logic [1:0] hr_t_q, hr_t_d;

    logic [3:0] digit;

    // Gated by rst_n so tick reads 0 during reset even when CLK_DIV = 1.
    assign tick = rst_n && (cnt_q == CNT_MAX);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // Whole carry chain resolves in one pass, so only legal BCD reaches the registers.
    always_comb begin
        sec_u_d = sec_u_q;
        sec_t_d = sec_t_q;
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        hr_u_d  = hr_u_q;
        hr_t_d  = hr_t_q;
        if (tick) begin
            if (sec_u_q != 4'd9) begin
                sec_u_d = sec_u_q + 4'd1;
            end else begin
                sec_u_d = 4'd0;
                if (sec_t_q != 3'd5) begin
                    sec_t_d = sec_t_q + 3'd1;
                end else begin
                    sec_t_d = 3'd0;
                    if (min_u_q != 4'd9) begin
                        min_u_d = min_u_q + 4'd1;
                    end else begin
                        min_u_d = 4'd0;
                        if (min_t_q != 3'd5) begin
                            min_t_d = min_t_q + 3'd1;
                        end else begin
                            min_t_d = 3'd0;
                            if (hr_t_q == 2'd2 && hr_u_q == 4'd3) begin
                                hr_t_d = 2'd0;
                                hr_u_d = 4'd0;
                            end else if (hr_u_q == 4'd9) begin
                                hr_u_d = 4'd0;
                                hr_t_d = hr_t_q + 2'd1;
                            end else begin
                                hr_u_d = hr_u_q + 4'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sec_u_q <= 4'd0;
            sec_t_q <= 3'd0;
            min_u_q <= 4'd0;
            min_t_q <= 3'd0;
            hr_u_q  <= 4'd0;
            hr_t_q  <= 2'd0;
        end else begin
            cnt_q   <= cnt_d;
            sec_u_q <= sec_u_d;
            sec_t_q <= sec_t_d;
            min_u_q <= min_u_d;
            min_t_q <= min_t_d;
            hr_u_q  <= hr_u_d;
            hr_t_q  <= hr_t_d;
        end
    end

    always_comb begin
        digit = 4'd0;
        case (DISPLAY_SEL)
            0:       digit = sec_u_q;
            1:       digit = {1'b0, sec_t_q};
            2:       digit = min_u_q;
            3:       digit = {1'b0, min_t_q};
            4:       digit = hr_u_q;
            5:       digit = {2'b00, hr_t_q};
            default: digit = 4'd0;
        endcase
    end

    assign {led4, led3, led2, led1} = digit;

endmodule

// File: tb/tb_binary_clock_top.sv
// Scoreboard bench: eight clock instances (one per display select) checked every
// cycle against a seconds-counter reference model.
module tb_binary_clock_top;

    localparam int N = 8;
    localparam int DIVS [N] = '{4, 4, 1, 1, 1, 1, 3, 1};
    localparam int SELS [N] = '{0, 1, 2, 3, 4, 5, 6, 7};

    logic       clk;
    logic       rst_n;
    logic [3:0] leds [N];

    int tests;
    int fails;
    bit done;

    logic [4*N-1:0] expq [$];

    // Reference model state: cycles into the current second, and seconds of day.
    int phase [N];
    int secs  [N];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        binary_clock_top #(
            .CLK_DIV    (DIVS[g]),
            .DISPLAY_SEL(SELS[g])
        ) u_dut (
            .clk  (clk),
            .rst_n(rst_n),
            .led1 (leds[g][0]),
            .led2 (leds[g][1]),
            .led3 (leds[g][2]),
            .led4 (leds[g][3])
        );
    end

    function automatic logic [3:0] show(input int sel, input int s);
        int v;
        case (sel)
            0:       v = s % 10;
            1:       v = (s % 60) / 10;
            2:       v = (s / 60) % 10;
            3:       v = ((s / 60) % 60) / 10;
            4:       v = (s / 3600) % 10;
            5:       v = (s / 3600) / 10;
            default: v = 0;
        endcase
        return 4'(v);
    endfunction

    // Drive rst_n for the next rising edge and push what every instance must show after it.
    task automatic step(input logic r);
        logic [4*N-1:0] e;
        @(negedge clk);
        rst_n = r;
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (!r) begin
                phase[i] = 0;
                secs[i]  = 0;
            end else if (phase[i] == DIVS[i] - 1) begin
                phase[i] = 0;
                secs[i]  = (secs[i] + 1) % 86400;
            end else begin
                phase[i] = phase[i] + 1;
            end
            e[4*i +: 4] = show(SELS[i], secs[i]);
        end
        expq.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge once stimulus has started.
    initial begin
        logic [4*N-1:0] e;
        bit started;
        started = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                started = 1'b1;
                e = expq.pop_front();
                for (int i = 0; i < N; i++) begin
                    tests++;
                    if (leds[i] !== e[4*i +: 4]) begin
                        fails++;
                        $display("FAIL leds[%0d] (div %0d sel %0d) at %0t: got %b, want %b",
                                 i, DIVS[i], SELS[i], $time, leds[i], e[4*i +: 4]);
                    end
                end
            end else if (started && !done) begin
                tests++;
                fails++;
                $display("FAIL scoreboard empty at %0t", $time);
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        done  = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            phase[i] = 0;
            secs[i]  = 0;
        end
        // Reset held, then a clean run past the first ten seconds of the div-4 instances.
        repeat (3) step(1'b0);
        repeat (45) step(1'b1);
        // Mid-operation reset after seven ticks of the div-4 instances.
        step(1'b0);
        repeat (28) step(1'b1);
        step(1'b0);
        repeat (12) step(1'b1);
        // Randomized reset pulses.
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 39) != 0);
        end
        // Full day plus a few cycles on the div-1 instances to cover 23:59:59 -> 00:00:00.
        step(1'b0);
        repeat (86405) step(1'b1);
        @(posedge clk);
        #2;
        done = 1'b1;
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
